// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

   // Controller states: serving hits, or refilling one line.
   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   // Instruction returned whenever there is no hit.
   localparam logic [31:0] NOP = 32'h0;

   // Width helpers, usable in constant expressions of the cache modules.
   function automatic int unsigned off_w(input int unsigned words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int unsigned idx_w(input int unsigned lines);
      return $clog2(lines);
   endfunction

   function automatic int unsigned tag_w(input int unsigned lines,
                                         input int unsigned words_per_line);
      return 32 - off_w(words_per_line) - idx_w(lines) - 2;
   endfunction

   // Widths for the default geometry (32 lines x 4 words).
   localparam int unsigned DEF_LINES          = 32;
   localparam int unsigned DEF_WORDS_PER_LINE = 4;
   localparam int unsigned OFF_W = off_w(DEF_WORDS_PER_LINE);
   localparam int unsigned IDX_W = idx_w(DEF_LINES);
   localparam int unsigned TAG_W = tag_w(DEF_LINES, DEF_WORDS_PER_LINE);

endpackage

// File: rtl/icache_direct_if.sv
// Refill bus between the instruction cache and main memory.
interface icache_direct_if;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_rdata;

   // Cache side issues the request and consumes refill beats.
   modport master (
      output mem_req,
      output mem_addr,
      input  mem_valid,
      input  mem_rdata
   );

   // Memory side answers the request with one word per valid beat.
   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_valid,
      output mem_rdata
   );

endinterface

// File: rtl/icache_line_store.sv
// Data, tag and valid storage: asynchronous read, single write port, bulk clear.
module icache_line_store
   import icache_pkg::*;
#(
   parameter  int unsigned LINES          = 32,
   parameter  int unsigned WORDS_PER_LINE = 4,
   localparam int unsigned OFF            = off_w(WORDS_PER_LINE),
   localparam int unsigned IDX            = idx_w(LINES),
   localparam int unsigned TAG            = tag_w(LINES, WORDS_PER_LINE)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [IDX-1:0]  rd_idx,
   input  logic [OFF-1:0]  rd_off,
   input  logic [TAG-1:0]  rd_tag,
   output logic [31:0]     rd_data,
   output logic            rd_match,
   input  logic            wr_en,
   input  logic [IDX-1:0]  wr_idx,
   input  logic [OFF-1:0]  wr_off,
   input  logic [31:0]     wr_data,
   input  logic            tag_wr,
   input  logic [TAG-1:0]  wr_tag,
   input  logic            wr_valid,
   input  logic            clr_all
);

   logic [31:0]    data_q [LINES][WORDS_PER_LINE];
   logic [TAG-1:0] tag_q  [LINES];
   logic [LINES-1:0] valid_q;

   assign rd_data  = data_q[rd_idx][rd_off];
   assign rd_match = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

   // Refill word write; data carries no reset since valid gates its use.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[wr_idx][wr_off] <= wr_data;
      end
   end

   // Tag write on the final refill beat.
   always_ff @(posedge clk) begin
      if (tag_wr) begin
         tag_q[wr_idx] <= wr_tag;
      end
   end

   // Valid bits: reset and invalidate clear all, the final beat sets one.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else if (clr_all) begin
         valid_q <= '0;
      end else if (tag_wr) begin
         valid_q[wr_idx] <= wr_valid;
      end
   end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with stall-on-miss line refill.
module icache_direct
   import icache_pkg::*;
#(
   parameter int unsigned LINES          = 32,
   parameter int unsigned WORDS_PER_LINE = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          pc,
   input  logic                 inv,
   output logic [31:0]          instr,
   output logic                 hit,
   output logic                 stall,
   output logic [31:0]          miss_count,
   icache_direct_if.master      mem
);

   localparam int unsigned OFF    = off_w(WORDS_PER_LINE);
   localparam int unsigned IDX    = idx_w(LINES);
   localparam int unsigned TAG    = tag_w(LINES, WORDS_PER_LINE);
   localparam int unsigned LINE_W = 30 - OFF;

   state_t              state_q, state_d;
   logic [OFF-1:0]      beat_q;
   logic [LINE_W-1:0]   line_q;
   logic                inv_seen_q;
   logic [31:0]         miss_q;

   logic [OFF-1:0]      pc_off;
   logic [IDX-1:0]      pc_idx;
   logic [TAG-1:0]      pc_tag;
   logic [31:0]         rd_data;
   logic                rd_match;
   logic                wr_en;
   logic                tag_wr;
   logic                start_miss;
   logic                last_beat;
   logic                unused_pc_bits;

   assign pc_off         = pc[OFF+1:2];
   assign pc_idx         = pc[OFF+IDX+1:OFF+2];
   assign pc_tag         = pc[31:OFF+IDX+2];
   assign unused_pc_bits = ^pc[1:0];
   assign last_beat      = (beat_q == '1);

   icache_line_store #(
      .LINES          (LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_store (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (pc_idx),
      .rd_off   (pc_off),
      .rd_tag   (pc_tag),
      .rd_data  (rd_data),
      .rd_match (rd_match),
      .wr_en    (wr_en),
      .wr_idx   (line_q[IDX-1:0]),
      .wr_off   (beat_q),
      .wr_data  (mem.mem_rdata),
      .tag_wr   (tag_wr),
      .wr_tag   (line_q[LINE_W-1:IDX]),
      .wr_valid (~(inv_seen_q | inv)),
      .clr_all  (inv)
   );

   // Next state, hit detection and refill bus drive.
   always_comb begin
      state_d      = state_q;
      hit          = 1'b0;
      start_miss   = 1'b0;
      wr_en        = 1'b0;
      tag_wr       = 1'b0;
      mem.mem_req  = 1'b0;
      mem.mem_addr = '0;
      case (state_q)
         IDLE: begin
            hit = rd_match;
            if (!rd_match) begin
               // Held off during reset so an aborted fill drops mem_req at once.
               start_miss   = ~reset;
               mem.mem_req  = ~reset;
               mem.mem_addr = {pc[31:OFF+2], {(OFF+2){1'b0}}};
               state_d      = FILL;
            end
         end
         FILL: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = {line_q, {(OFF+2){1'b0}}};
            if (mem.mem_valid) begin
               wr_en = 1'b1;
               if (last_beat) begin
                  tag_wr  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign instr      = hit ? rd_data : NOP;
   assign stall      = ~hit;
   assign miss_count = miss_q;

   // State, beat counter, miss counter and invalidate-during-fill flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         miss_q     <= '0;
         inv_seen_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_miss) begin
            miss_q <= miss_q + 32'd1;
            beat_q <= '0;
         end else if (wr_en) begin
            beat_q <= beat_q + 1'b1;
         end
         if (state_q == FILL && state_d == IDLE) begin
            inv_seen_q <= 1'b0;
         end else if (state_q == FILL && inv) begin
            inv_seen_q <= 1'b1;
         end
      end
   end

   // Line address of the refill in flight.
   always_ff @(posedge clk) begin
      if (start_miss) begin
         line_q <= pc[31:OFF+2];
      end
   end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache feeding the fetch stage of the pipelined MIPS datapath.
- Takes pcF; returns the instruction word combinationally on a hit.
- On a miss, raises a stall to the hazard unit and refills one line from main memory through a beat-by-beat handshake.

Parameters:
- LINES, 32, number of cache lines; power of 2, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears valid bits, FSM, counter.
- pc  in  32  fetch byte address (pcF); bits [1:0] ignored.
- inv  in  1  invalidate entire cache.
- instr  out  32  instruction word; 32'h0 (nop) when hit=0.
- hit  out  1  combinational: state IDLE, valid[index], and tag match.
- stall  out  1  ~hit; drives the stallF/stallD OR-in.
- mem_req  out  1  line refill request, level-held.
- mem_addr  out  32  line-aligned byte address of refill.
- mem_valid  in  1  one refill word present this cycle.
- mem_rdata  in  32  refill word, delivered in ascending word order.
- miss_count  out  32  number of refills started.

Behaviour:
- Address split, with OFF=log2(WORDS_PER_LINE) and IDX=log2(LINES); default widths in parentheses:
  - word offset = pc[OFF+1:2] ([3:2]).
  - index = pc[OFF+IDX+1:OFF+2] ([8:4]).
  - tag = pc[31:OFF+IDX+2] ([31:9], 23 bits).
- Storage: data array LINES×WORDS_PER_LINE×32, tag array, and valid bit per line. Reads are asynchronous; writes occur on clk.
- Reset: all valid=0, state=IDLE, beat=0, miss_count=0. After reset, outputs are hit=0, stall=1, instr=0, mem_req=0 until pc is presented and a miss begins.
- FSM IDLE:
  - hit=1: instr=data[index][offset]; no state change.
  - hit=0 (miss): mem_req=1 combinationally in the same cycle. mem_addr = {pc[31:OFF+2], OFF+2 zero bits}. miss_count += 1 (wraps at 2^32). Go to FILL with beat=0, and latch the line address and tag.
- FSM FILL:
  - mem_req=1 and mem_addr = latched address.
  - Each cycle with mem_valid=1: write mem_rdata to data[latched index][beat], then beat += 1.
  - mem_valid=0 cycles are gaps; beat holds.
  - On the beat with beat=WORDS_PER_LINE-1: write tag, set valid=1 (unless an inv occurred during this fill), go to IDLE.
  - mem_req deasserts the cycle after the last beat.
- Miss latency: the refill takes WORDS_PER_LINE beats plus gap cycles. hit rises in the cycle after the last beat, so the minimum miss penalty is WORDS_PER_LINE+1 stall cycles.
- pc is required stable while stall=1 (held by stallF). The cache does not re-check pc during FILL.
- inv:
  - In IDLE: all valid bits clear at the next edge. hit evaluates against the pre-clear valids in the same cycle.
  - In FILL: the fill completes, but that line's valid is left 0. Set a sticky flag, cleared on entry to IDLE.
- Reset mid-FILL aborts the fill: mem_req=0 in the next cycle. The memory side treats a dropped mem_req as abort and discards outstanding beats. Partially written data is harmless because valid=0.
- mem_valid while in IDLE is ignored.
- Simultaneous reset and inv: reset wins.

Decomposition:
- Shared package icache_pkg holds:
  - the IDLE/FILL state encoding (1 bit);
  - derived width constants OFF_W, IDX_W, TAG_W computed from the parameters;
  - NOP constant 32'h0.
- One natural sub-module: icache_line_store, containing the data, tag and valid arrays, the asynchronous read port, the single write port, and the bulk valid-clear.
- The FSM, beat counter and miss counter stay in icache_direct.

Test Plan:
- Cold miss:
  - Stimulus: reset, pc=0x0000_0040; memory supplies words 0xA0..0xA3 with no gaps.
  - Response: stall=1 for 5 cycles; mem_addr=0x40; miss_count=1; then hit=1 and instr=0xA0.
- Same-line hits:
  - Stimulus: after the fill, pc=0x44, then 0x48, then 0x4C.
  - Response: hit=1 every cycle; instr 0xA1, 0xA2, 0xA3; no mem_req; miss_count stays 1.
- Conflict miss:
  - Stimulus: pc=0x240 (same index 4, tag 1); memory supplies 0xB0..0xB3; then pc=0x40.
  - Response: the first access misses and returns 0xB0. The pc=0x40 access misses again; miss_count=3.
- Gapped refill:
  - Stimulus: mem_valid pattern 1,0,0,1,1,0,1.
  - Response: beat advances only on 1s; stall lasts 8 cycles; all words land in order.
- Reset mid-fill:
  - Stimulus: assert reset after the 2nd beat.
  - Response: next cycle mem_req=0 and miss_count=0. Re-presenting the same pc misses and refetches from word 0.
- Invalidate:
  - Stimulus: in IDLE with valid lines, pulse inv.
  - Response: the next access to 0x40 misses. An inv during FILL leaves that line invalid, so the following cycle misses again.
